// File: rtl/cache_bus_arbiter.sv
// Shares one sram-like memory port between the i_cache and d_cache masters.
// One transaction in flight; the grant is held from the forwarded request until data_ok.
module cache_bus_arbiter #(
    parameter int ARB_MODE = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_req,
    input  logic        i_wr,
    input  logic [1:0]  i_size,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_wdata,
    output logic [31:0] i_rdata,
    output logic        i_addr_ok,
    output logic        i_data_ok,
    input  logic        d_req,
    input  logic        d_wr,
    input  logic [1:0]  d_size,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic [31:0] d_rdata,
    output logic        d_addr_ok,
    output logic        d_data_ok,
    output logic        m_req,
    output logic        m_wr,
    output logic [1:0]  m_size,
    output logic [31:0] m_addr,
    output logic [31:0] m_wdata,
    input  logic [31:0] m_rdata,
    input  logic        m_addr_ok,
    input  logic        m_data_ok
);

    typedef enum logic [2:0] {IDLE, HOLD_I, HOLD_D, WAIT_I, WAIT_D} state_t;

    typedef struct packed {
        logic        wr;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
    } mreq_t;

    state_t state, state_nx;
    logic   last;       // owner of the most recent accepted address, 1 = data master
    logic   win_d, win_i;
    logic   own_v, own_d;
    mreq_t  i_fld, d_fld, m_fld;

    assign i_fld = {i_wr, i_size, i_addr, i_wdata};
    assign d_fld = {d_wr, d_size, d_addr, d_wdata};

    // On a tie the data master wins in fixed mode, or in round-robin when inst won last.
    assign win_d = d_req & ((ARB_MODE == 0) | ~i_req | ~last);
    assign win_i = i_req & ~win_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            last  <= 1'b1;
        end else begin
            state <= state_nx;
            if (m_req && m_addr_ok)
                last <= own_d;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (own_v) begin
                    if (m_addr_ok) state_nx = own_d ? WAIT_D : WAIT_I;
                    else           state_nx = own_d ? HOLD_D : HOLD_I;
                end
            end
            HOLD_I: if (m_addr_ok) state_nx = WAIT_I;
            HOLD_D: if (m_addr_ok) state_nx = WAIT_D;
            WAIT_I: if (m_data_ok) state_nx = IDLE;
            WAIT_D: if (m_data_ok) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Once in HOLD_x the grant stays with x even if the other master starts requesting.
    always_comb begin
        own_v = 1'b0;
        own_d = 1'b0;
        case (state)
            IDLE: begin
                own_v = win_d | win_i;
                own_d = win_d;
            end
            HOLD_I: own_v = 1'b1;
            HOLD_D: begin
                own_v = 1'b1;
                own_d = 1'b1;
            end
            default: ;
        endcase
        if (rst)
            own_v = 1'b0;
    end

    always_comb begin
        m_fld     = '0;
        if (own_v)
            m_fld = own_d ? d_fld : i_fld;
        m_req     = own_v;
        m_wr      = m_fld.wr;
        m_size    = m_fld.size;
        m_addr    = m_fld.addr;
        m_wdata   = m_fld.wdata;
        i_addr_ok = m_addr_ok & own_v & ~own_d;
        d_addr_ok = m_addr_ok & own_v & own_d;
        i_data_ok = m_data_ok & (state == WAIT_I) & ~rst;
        d_data_ok = m_data_ok & (state == WAIT_D) & ~rst;
        i_rdata   = m_rdata;
        d_rdata   = m_rdata;
    end

endmodule
